// File: rtl/jpeg_rle_expander_if.sv
// Stream interface of the JPEG run-length expander.
// One bundle carries both sides of the expander:
//  - the symbol input stream (in_*), driven by the Huffman decoder;
//  - the coefficient output stream (out_*), consumed by the dezigzag stage;
//  - the overrun flag.
// Modports:
//  - master: the surrounding environment. It drives the symbols and out_ready.
//  - slave: the expander itself.
interface jpeg_rle_expander_if #(
  parameter int COEF_W = 12,
  parameter int IDX_W  = 6
);
  // Symbol stream (entropy decoder -> expander).
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_run;
  logic [COEF_W-1:0] in_value;
  logic              in_eob;

  // Coefficient stream (expander -> dezigzag).
  logic              out_valid;
  logic              out_ready;
  logic [COEF_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  // One-cycle pulse when a symbol ran past the end of a block.
  logic              err_overrun;

  modport master (
    output in_valid, in_run, in_value, in_eob, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, err_overrun
  );

  modport slave (
    input  in_valid, in_run, in_value, in_eob, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, err_overrun
  );
endinterface

// File: rtl/jpeg_rle_expander.sv
// JPEG run-length expander.
// Turns (run, value, eob) symbols into a flat stream of BLOCK_LEN
// coefficients per block, with out_idx giving the position in the block
// and out_last marking the final coefficient.
//
// Handshake rules, identical on both sides:
//  - A transfer happens on a rising edge where valid && ready.
//  - valid never depends on ready.
//  - While valid=1 and ready=0, the payload (data/idx/last) holds steady.
//  - in_ready is a pure decode of the state. It is high only in IDLE and
//    never in reset, so there is no combinational path from out_ready.
//
// Only one symbol is in flight at a time:
//  - IDLE accepts a symbol;
//  - ZEROS emits its run of zeros;
//  - VALUE emits the coefficient itself;
//  - FILL pads the rest of the block with zeros after an end-of-block.
// A run that would cross the end of the block is cut at the last position.
// That beat is marked last, the remaining zeros and the value are dropped,
// and err_overrun pulses on the following cycle.
module jpeg_rle_expander #(
  parameter int COEF_W    = 12,
  parameter int BLOCK_LEN = 64,
  parameter int IDX_W     = $clog2(BLOCK_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  jpeg_rle_expander_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    VALUE = 2'd2,
    FILL  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [COEF_W-1:0] val, val_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              overrun;
  logic              in_hs;
  logic              out_hs;

  // Handshake qualifiers for both streams.
  always_comb begin
    in_hs  = bus.in_valid && bus.in_ready;
    out_hs = bus.out_valid && bus.out_ready;
  end

  // Output decode: every output is a function of the current state registers.
  always_comb begin
    bus.in_ready  = rst_n && (state == IDLE);
    bus.out_valid = (state != IDLE);
    bus.out_data  = (state == VALUE) ? val : '0;
    bus.out_idx   = idx;
    bus.out_last  = (state != IDLE) && (idx == IDX_MAX);
    dbg_state     = state;
  end

  // Next-state logic. All state holds unless a handshake occurs,
  // so back-pressure on the output freezes the expander.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    val_n   = val;
    idx_n   = idx;
    overrun = 1'b0;
    case (state)
      IDLE: begin
        if (in_hs) begin
          if (bus.in_eob) begin
            state_n = FILL;
          end else if (bus.in_run != 4'd0) begin
            cnt_n   = bus.in_run;
            val_n   = bus.in_value;
            state_n = ZEROS;
          end else begin
            val_n   = bus.in_value;
            state_n = VALUE;
          end
        end
      end
      ZEROS: begin
        if (out_hs) begin
          if (idx == IDX_MAX) begin
            // The run reached the block end. Drop whatever is left of it.
            overrun = 1'b1;
            cnt_n   = 4'd0;
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 4'd1;
            idx_n = idx + IDX_ONE;
            if (cnt == 4'd1) begin
              state_n = VALUE;
            end
          end
        end
      end
      VALUE: begin
        if (out_hs) begin
          // Natural wrap: a value at the last position closes the block.
          idx_n   = idx + IDX_ONE;
          state_n = IDLE;
        end
      end
      FILL: begin
        if (out_hs) begin
          if (idx == IDX_MAX) begin
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx + IDX_ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State registers. The asynchronous reset discards any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      val   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      val   <= val_n;
      idx   <= idx_n;
    end
  end

  // Registered one-cycle overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_overrun <= 1'b0;
    end else begin
      bus.err_overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_jpeg_rle_expander.sv
// Testbench for jpeg_rle_expander.
// Each stimulus symbol is pushed into an expected-beat queue by a small
// block model. A monitor compares every output handshake against that
// queue. A table of symbols, each with a hand-counted beat total, covers
// the main patterns. Hand-written sequences cover the overrun, random
// back-pressure and mid-block reset.
module tb_jpeg_rle_expander;
  localparam int COEF_W    = 12;
  localparam int BLOCK_LEN = 64;
  localparam int IDX_W     = 6;
  localparam int W         = COEF_W + IDX_W + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  jpeg_rle_expander_if #(.COEF_W(COEF_W), .IDX_W(IDX_W)) bus();

  jpeg_rle_expander #(
    .COEF_W(COEF_W), .BLOCK_LEN(BLOCK_LEN), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        run;
    logic [COEF_W-1:0] value;
    logic              eob;
    int                exp_beats;
  } vec_t;

  vec_t           vecs [9];
  logic [W-1:0]   exp_q [$];
  int             n_cmp = 0;
  int             n_fail = 0;
  int             beat_cnt = 0;
  int             err_seen = 0;
  int             exp_err = 0;
  int             model_idx = 0;
  bit             rnd_en = 1'b0;

  task automatic check(input bit ok, input string name, input int got, input int req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push_beat(input logic [COEF_W-1:0] data, input int i);
    logic [IDX_W-1:0] iw;
    iw = IDX_W'(i);
    exp_q.push_back({data, iw, (i == BLOCK_LEN - 1)});
  endtask

  // Block model: expected beats for one symbol.
  task automatic model_sym(input logic [3:0] run, input logic [COEF_W-1:0] value, input logic eob);
    bit drop;
    drop = 1'b0;
    if (eob) begin
      for (int k = model_idx; k < BLOCK_LEN; k++) push_beat('0, k);
      model_idx = 0;
    end else begin
      for (int k = 0; k < int'(run); k++) begin
        push_beat('0, model_idx);
        if (model_idx == BLOCK_LEN - 1) begin
          model_idx = 0;
          exp_err++;
          drop = 1'b1;
          break;
        end
        model_idx++;
      end
      if (!drop) begin
        push_beat(value, model_idx);
        model_idx = (model_idx + 1) % BLOCK_LEN;
      end
    end
  endtask

  // Driver: present one symbol and hold it until it is accepted.
  task automatic send(input logic [3:0] run, input logic [COEF_W-1:0] value, input logic eob);
    int t;
    model_sym(run, value, eob);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_run   = run;
    bus.in_value = value;
    bus.in_eob   = eob;
    t = 0;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check(1'b0, "in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(t < 5000, "drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: compare handshakes and check the payload holds while stalled.
  task automatic monitor();
    bit           stalled;
    logic [W-1:0] held, got, e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        got = {bus.out_data, bus.out_idx, bus.out_last};
        if (bus.err_overrun) err_seen++;
        if (stalled) check(bus.out_valid && got == held, "stall_hold", int'(got), int'(held));
        if (bus.out_valid && bus.out_ready) begin
          beat_cnt++;
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", int'(got), 0);
          end else begin
            e = exp_q.pop_front();
            check(got == e, "beat", int'(got), int'(e));
          end
        end else begin
          stalled = bus.out_valid;
          held = got;
        end
      end
    end
  endtask

  // Back-pressure driver: changes out_ready just after each rising edge.
  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic check_quiet(input string name);
    check(bus.out_valid == 1'b0, {name, "_out_valid"}, bus.out_valid, 0);
    check(bus.out_data == '0, {name, "_out_data"}, int'(bus.out_data), 0);
    check(bus.out_idx == '0, {name, "_out_idx"}, int'(bus.out_idx), 0);
    check(bus.out_last == 1'b0, {name, "_out_last"}, bus.out_last, 0);
    check(bus.err_overrun == 1'b0, {name, "_err"}, bus.err_overrun, 0);
  endtask

  initial begin
    int b0, t;
    bus.in_valid  = 1'b0;
    bus.in_run    = 4'd0;
    bus.in_value  = '0;
    bus.in_eob    = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{4'd2,  12'd5,             1'b0, 3};
    vecs[1] = '{4'd0,  12'hFFD,           1'b0, 1};
    vecs[2] = '{4'd0,  12'd0,             1'b1, 60};
    vecs[3] = '{4'd15, 12'd0,             1'b0, 16};
    vecs[4] = '{4'd15, 12'd0,             1'b0, 16};
    vecs[5] = '{4'd15, 12'd0,             1'b0, 16};
    vecs[6] = '{4'd15, 12'd0,             1'b0, 16};
    vecs[7] = '{4'd0,  12'd7,             1'b0, 1};
    vecs[8] = '{4'd0,  12'd0,             1'b1, 63};

    fork
      monitor();
      ready_driver();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check(bus.in_ready == 1'b0, "reset_in_ready", bus.in_ready, 0);
    check(dbg_state == 2'd0, "reset_state", dbg_state, 0);
    check_quiet("reset");
    rst_n = 1'b1;
    #1;
    check(bus.in_ready == 1'b1, "in_ready_after_reset", bus.in_ready, 1);
    repeat (3) @(negedge clk);
    check_quiet("idle");

    // Table-driven symbols: mixed block, four ZRLs, value at next block start.
    for (int i = 0; i < 9; i++) begin
      b0 = beat_cnt;
      send(vecs[i].run, vecs[i].value, vecs[i].eob);
      wait_drain();
      check(beat_cnt - b0 == vecs[i].exp_beats, "vec_beats", beat_cnt - b0, vecs[i].exp_beats);
    end
    check(err_seen == 0, "no_err_table", err_seen, 0);

    // Overrun: 62 ones, then run=3 crosses the block end.
    b0 = beat_cnt;
    for (int i = 0; i < 62; i++) send(4'd0, 12'd1, 1'b0);
    send(4'd3, 12'd9, 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);
    check(beat_cnt - b0 == 64, "overrun_beats", beat_cnt - b0, 64);
    check(err_seen == 1, "overrun_pulse", err_seen, 1);
    check(exp_err == 1, "overrun_model", exp_err, 1);
    b0 = beat_cnt;
    send(4'd0, 12'd0, 1'b1);
    wait_drain();
    check(beat_cnt - b0 == 64, "after_overrun_block", beat_cnt - b0, 64);

    // Random back-pressure: same beats as with out_ready held high.
    rnd_en = 1'b1;
    b0 = beat_cnt;
    send(4'd4, 12'd2, 1'b0);
    send(4'd0, 12'd0, 1'b1);
    wait_drain();
    rnd_en = 1'b0;
    check(beat_cnt - b0 == 64, "stall_block_beats", beat_cnt - b0, 64);

    // Reset in the middle of a zero run.
    send(4'd15, 12'd0, 1'b0);
    t = 0;
    while (!(bus.out_valid && bus.out_idx == IDX_W'(10)) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(t < 100, "reach_idx10", t, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check(bus.in_ready == 1'b0, "midreset_in_ready", bus.in_ready, 0);
    check_quiet("midreset");
    exp_q.delete();
    model_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    b0 = beat_cnt;
    send(4'd0, 12'd0, 1'b1);
    wait_drain();
    check(beat_cnt - b0 == 64, "post_reset_block", beat_cnt - b0, 64);
    check(err_seen == 1, "total_err", err_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/jpeg_rle_expander.md
Name: jpeg_rle_expander

Overview:
- Run-length decoder for the JPEG coefficient path.
- Converts a stream of (run, value, eob) symbols from the entropy-decode stage into a flat stream of BLOCK_LEN coefficients per block, with per-block last marking.
- It is the inverse of the zero-run encoder.
- Sits between the Huffman decoder and the dezigzag/dequantiser stage; valid/ready on both sides.

Parameters:
- COEF_W, 12, coefficient width (two's complement), for in_value and out_data.
- BLOCK_LEN, 64, coefficients per block; must be a power of two, at least 16.
- IDX_W, $clog2(BLOCK_LEN), width of the coefficient index.

Ports:
- clk  input  1  clock; all state rises on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  symbol valid.
- in_ready  output  1  symbol accepted when in_valid && in_ready.
- in_run  input  4  zero-run length preceding value (0..15).
- in_value  input  COEF_W  nonzero coefficient (0 allowed, for ZRL).
- in_eob  input  1  end-of-block; in_run and in_value are ignored.
- out_valid  output  1  coefficient valid.
- out_ready  input  1  downstream accepts.
- out_data  output  COEF_W  coefficient.
- out_idx  output  IDX_W  position of out_data within the block.
- out_last  output  1  high on the beat where out_idx == BLOCK_LEN-1.
- err_overrun  output  1  one-cycle pulse: symbol overran the block.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, idx=0, cnt=0.
  - in_ready=0 during reset.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, err_overrun=0.
  - Reset mid-block discards all partial state. The next block starts at idx 0.
- Out handshake occurs when out_valid && out_ready. out_data, out_idx and out_last must hold stable while out_valid=1 and out_ready=0.
- Registers: latched run cnt (4b), latched value, idx (IDX_W), state.
- out_idx = idx. out_last = out_valid && (idx == BLOCK_LEN-1).
- States:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On accept with in_eob=1: go to FILL.
    - Else if in_run>0: cnt=in_run, latch value, go to ZEROS.
    - Else: latch value, go to VALUE.
  - ZEROS:
    - out_valid=1, out_data=0.
    - On handshake: cnt-=1 and idx+=1.
    - If cnt==1 at the handshake, go to VALUE.
    - If idx==BLOCK_LEN-1 at the handshake, it is an overrun:
      - the beat is marked last;
      - err_overrun pulses the next cycle;
      - the remaining zeros and the value are dropped;
      - idx=0, go to IDLE.
  - VALUE:
    - out_valid=1, out_data=latched value.
    - On handshake: idx+=1, wrapping to 0 after BLOCK_LEN-1; go to IDLE.
  - FILL:
    - out_valid=1, out_data=0.
    - On handshake: idx+=1.
    - If idx==BLOCK_LEN-1 at the handshake: idx=0, go to IDLE.
    - EOB at idx 0 yields BLOCK_LEN zeros.
- ZRL (run=15, value=0) needs no special case: it emits 16 zeros.
- A value landing at idx BLOCK_LEN-1 completes the block normally; the next symbol starts a new block.
- Latency: the first output beat is valid on the cycle after acceptance.
- Throughput: one symbol costs run+1 output beats plus one IDLE cycle. No input is accepted while expanding.
- Back-pressure: out_ready=0 freezes all state. No beats are duplicated or lost.
- err_overrun is a registered one-cycle pulse. It does not block further operation.
- in_ready is a pure decode of state (no combinational path from out_ready).

Test Plan:
- Reset then idle → all outputs 0. in_ready=1 on the first cycle after rst_n rises.
- Symbols (run=2,val=5), (run=0,val=-3), EOB, with out_ready=1:
  - out_data 0,0,5,-3 at idx 0..3;
  - then 60 zeros at idx 4..63;
  - out_last only at idx 63;
  - the next block starts at idx 0.
- Four ZRL symbols (15,0) then (run=0,val=7):
  - 64 zeros total at idx 0..63, then 7 at idx 0 of the next block;
  - err_overrun=0 throughout.
- 62 symbols (0,1) then (run=3,val=9):
  - ones at idx 0..61;
  - zeros at idx 62 and 63, with last at 63;
  - err_overrun pulses once, and 9 is never output.
- Random out_ready (50%) during (run=4,val=2) and EOB → the beat sequence is identical to the out_ready=1 case. Outputs are stable while stalled.
- Assert rst_n=0 mid-ZEROS (idx=10) → outputs go to 0 asynchronously. After release, EOB produces 64 zeros starting at idx 0.
